// File: rtl/snn_window_ctrl.sv
// snn_window_ctrl
// Sequencing controller for a 4-input / 2-output spiking network.
// Accepts one four-channel sensor sample (in_valid/in_ready), holds it on the
// network inputs, clears the network, then pulses snn_en once per time step
// for WINDOW steps while counting output spikes of neurons 0 and 1. At the end
// of the window it presents saturated counts and a steering decision
// (res_valid/res_ready).
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid, in_ready       sample handshake (in_ready = controller idle)
//   s_fl/s_ml/s_mr/s_fr      sensor readings (12 bit)
//   snn_fl/ml/mr/fr          registered sensor values driven to the network
//   snn_rst, snn_en          network synchronous reset / time-step enable
//   snn_spike                network output spikes (bits 0 and 1 are counted)
//   abort                    cancel evaluation in CLEAR/RUN/DRAIN
//   res_valid, res_ready     result handshake
//   cnt_l, cnt_r, decision   spike counts and 00 none/01 left/10 right/11 ambiguous
module snn_window_ctrl #(
    parameter int EXCNUM     = 2,
    parameter int WINDOW     = 16,
    parameter int STEP_DIV   = 4,
    parameter int CLR_CYCLES = 2,
    parameter int CNTW       = 8,
    parameter int MARGIN     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [11:0]       s_fl,
    input  logic [11:0]       s_ml,
    input  logic [11:0]       s_mr,
    input  logic [11:0]       s_fr,
    output logic [11:0]       snn_fl,
    output logic [11:0]       snn_ml,
    output logic [11:0]       snn_mr,
    output logic [11:0]       snn_fr,
    output logic              snn_rst,
    output logic              snn_en,
    input  logic [EXCNUM-1:0] snn_spike,
    input  logic              abort,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNTW-1:0]   cnt_l,
    output logic [CNTW-1:0]   cnt_r,
    output logic [1:0]        decision
);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

    localparam int SW = $clog2(STEP_DIV + 1);
    localparam int PW = $clog2(WINDOW + 1);
    localparam int CW = $clog2(CLR_CYCLES + 1);
    localparam logic [SW-1:0]   STEP_LAST  = SW'(STEP_DIV - 1);
    localparam logic [PW-1:0]   PULSE_LAST = PW'(WINDOW - 1);
    localparam logic [CW-1:0]   CLR_LAST   = CW'(CLR_CYCLES - 1);
    localparam logic [CNTW-1:0] CNT_MAX    = {CNTW{1'b1}};
    localparam logic [CNTW:0]   MARG       = (CNTW + 1)'(MARGIN);

    state_t          state, state_nx;
    logic [SW-1:0]   step, step_nx;
    logic [PW-1:0]   pulse, pulse_nx;
    logic [CW-1:0]   clr_cnt, clr_nx;
    logic [CNTW-1:0] acc_l, acc_r, acc_l_nx, acc_r_nx, acc_l_upd, acc_r_upd;
    logic [CNTW-1:0] cnt_l_nx, cnt_r_nx;
    logic [1:0]      dec_nx, dec_calc;
    logic            en_nx, rst_nx, res_valid_nx, smp, sampling, capture;
    logic [CNTW:0]   l_ext, r_ext, l_plus, r_plus;

    assign in_ready = (state == IDLE);
    assign capture  = (state == IDLE) && in_valid;

    // smp marks the cycle right after an enable pulse: the only cycle in which
    // the network output of that time step is valid.
    assign sampling  = smp && (state == RUN || state == DRAIN);
    assign acc_l_upd = (sampling && snn_spike[0] && acc_l != CNT_MAX) ? acc_l + 1'b1 : acc_l;
    assign acc_r_upd = (sampling && snn_spike[1] && acc_r != CNT_MAX) ? acc_r + 1'b1 : acc_r;

    // Decision uses the counts including the DRAIN-cycle sample, widened by
    // one bit so count+MARGIN cannot wrap.
    assign l_ext  = {1'b0, acc_l_upd};
    assign r_ext  = {1'b0, acc_r_upd};
    assign l_plus = l_ext + MARG;
    assign r_plus = r_ext + MARG;

    always_comb begin
        dec_calc = 2'b11;
        if (acc_l_upd == '0 && acc_r_upd == '0) dec_calc = 2'b00;
        else if (l_ext > r_plus)                dec_calc = 2'b01;
        else if (r_ext > l_plus)                dec_calc = 2'b10;
    end

    always_comb begin
        state_nx     = state;
        step_nx      = step;
        pulse_nx     = pulse;
        clr_nx       = clr_cnt;
        acc_l_nx     = acc_l_upd;
        acc_r_nx     = acc_r_upd;
        en_nx        = 1'b0;
        res_valid_nx = res_valid;
        cnt_l_nx     = cnt_l;
        cnt_r_nx     = cnt_r;
        dec_nx       = decision;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = CLEAR;
                    clr_nx   = '0;
                    acc_l_nx = '0;
                    acc_r_nx = '0;
                end
            end
            CLEAR: begin
                if (clr_cnt == CLR_LAST) begin
                    state_nx = RUN;
                    step_nx  = '0;
                    pulse_nx = '0;
                    en_nx    = 1'b1;
                end else begin
                    clr_nx = clr_cnt + 1'b1;
                end
            end
            RUN: begin
                if (step == STEP_LAST) begin
                    step_nx = '0;
                    if (pulse == PULSE_LAST) begin
                        state_nx = DRAIN;
                    end else begin
                        pulse_nx = pulse + 1'b1;
                        en_nx    = 1'b1;
                    end
                end else begin
                    step_nx = step + 1'b1;
                end
            end
            DRAIN: begin
                state_nx     = DONE;
                res_valid_nx = 1'b1;
                cnt_l_nx     = acc_l_upd;
                cnt_r_nx     = acc_r_upd;
                dec_nx       = dec_calc;
            end
            DONE: begin
                if (res_ready) begin
                    state_nx     = IDLE;
                    res_valid_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
        // abort overrides everything in the active phases, including the
        // DRAIN cycle that would otherwise publish a result.
        if (abort && (state == CLEAR || state == RUN || state == DRAIN)) begin
            state_nx     = IDLE;
            en_nx        = 1'b0;
            acc_l_nx     = '0;
            acc_r_nx     = '0;
            res_valid_nx = res_valid;
            cnt_l_nx     = cnt_l;
            cnt_r_nx     = cnt_r;
            dec_nx       = decision;
        end
        rst_nx = !(state_nx == RUN || state_nx == DRAIN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            step      <= '0;
            pulse     <= '0;
            clr_cnt   <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            smp       <= 1'b0;
            snn_en    <= 1'b0;
            snn_rst   <= 1'b1;
            res_valid <= 1'b0;
            cnt_l     <= '0;
            cnt_r     <= '0;
            decision  <= 2'b00;
        end else begin
            state     <= state_nx;
            step      <= step_nx;
            pulse     <= pulse_nx;
            clr_cnt   <= clr_nx;
            acc_l     <= acc_l_nx;
            acc_r     <= acc_r_nx;
            smp       <= snn_en;
            snn_en    <= en_nx;
            snn_rst   <= rst_nx;
            res_valid <= res_valid_nx;
            cnt_l     <= cnt_l_nx;
            cnt_r     <= cnt_r_nx;
            decision  <= dec_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snn_fl <= '0;
            snn_ml <= '0;
            snn_mr <= '0;
            snn_fr <= '0;
        end else if (capture) begin
            snn_fl <= s_fl;
            snn_ml <= s_ml;
            snn_mr <= s_mr;
            snn_fr <= s_fr;
        end
    end

endmodule

// File: tb/tb_snn_window_ctrl.sv
// Testbench for snn_window_ctrl: a default instance and a small-counter,
// one-cycle-step instance (CNTW=4, WINDOW=20, STEP_DIV=1). Expected pulse
// timing, counts and decision come from the timing rules applied to the
// per-cycle spike table.
module tb_snn_window_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, res_ready, abort;
    logic [11:0] s_fl, s_ml, s_mr, s_fr;
    logic [1:0]  spike;
    int          sel;

    logic        a_ready, a_srst, a_en, a_rv, b_ready, b_srst, b_en, b_rv;
    logic [11:0] a_fl, a_ml, a_mr, a_fr, b_fl, b_ml, b_mr, b_fr;
    logic [7:0]  a_cl, a_cr;
    logic [3:0]  b_cl, b_cr;
    logic [1:0]  a_dec, b_dec;

    snn_window_ctrl u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 0), .in_ready(a_ready),
        .s_fl(s_fl), .s_ml(s_ml), .s_mr(s_mr), .s_fr(s_fr),
        .snn_fl(a_fl), .snn_ml(a_ml), .snn_mr(a_mr), .snn_fr(a_fr),
        .snn_rst(a_srst), .snn_en(a_en), .snn_spike(spike), .abort(abort && sel == 0),
        .res_valid(a_rv), .res_ready(res_ready && sel == 0),
        .cnt_l(a_cl), .cnt_r(a_cr), .decision(a_dec)
    );

    snn_window_ctrl #(.CNTW(4), .WINDOW(20), .STEP_DIV(1)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(b_ready),
        .s_fl(s_fl), .s_ml(s_ml), .s_mr(s_mr), .s_fr(s_fr),
        .snn_fl(b_fl), .snn_ml(b_ml), .snn_mr(b_mr), .snn_fr(b_fr),
        .snn_rst(b_srst), .snn_en(b_en), .snn_spike(spike), .abort(abort && sel == 1),
        .res_valid(b_rv), .res_ready(res_ready && sel == 1),
        .cnt_l(b_cl), .cnt_r(b_cr), .decision(b_dec)
    );

    logic        o_ready, o_srst, o_en, o_rv;
    logic [11:0] o_fl, o_ml, o_mr, o_fr;
    logic [7:0]  o_cl, o_cr;
    logic [1:0]  o_dec;

    always_comb begin
        o_ready = a_ready; o_srst = a_srst; o_en = a_en; o_rv = a_rv;
        o_fl = a_fl; o_ml = a_ml; o_mr = a_mr; o_fr = a_fr;
        o_cl = a_cl; o_cr = a_cr; o_dec = a_dec;
        if (sel == 1) begin
            o_ready = b_ready; o_srst = b_srst; o_en = b_en; o_rv = b_rv;
            o_fl = b_fl; o_ml = b_ml; o_mr = b_mr; o_fr = b_fr;
            o_cl = {4'b0, b_cl}; o_cr = {4'b0, b_cr}; o_dec = b_dec;
        end
    end

    int clr = 2, win = 16, sdiv = 4, cwid = 8;
    int checks = 0, errors = 0;
    logic [1:0] spk [0:127];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int which);
        sel = which;
        if (which == 0) begin win = 16; sdiv = 4; cwid = 8; end
        else            begin win = 20; sdiv = 1; cwid = 4; end
    endtask

    // k counts cycles after the capture edge (k=1 is the first CLEAR cycle).
    function automatic bit pulse_at(input int k);
        return k >= clr + 1 && (k - clr - 1) % sdiv == 0 && (k - clr - 1) / sdiv < win;
    endfunction

    // mode 0: constant a; 1: a only outside sample cycles;
    // 2: first a sample cycles carry bit0, first b carry bit1, noise elsewhere;
    // 3: fully random.
    task automatic fill(input int mode, input int a, input int b);
        int n = 0;
        for (int k = 0; k < 128; k++) begin
            bit samp = (k >= 1) && pulse_at(k - 1);
            case (mode)
                0: spk[k] = 2'(a);
                1: spk[k] = samp ? 2'b00 : 2'(a);
                2: if (samp) begin spk[k] = {n < b, n < a}; n++; end
                   else spk[k] = 2'($urandom);
                default: spk[k] = 2'($urandom);
            endcase
        end
    endtask

    function automatic logic [1:0] decide(input int l, input int r);
        if (l == 0 && r == 0) return 2'b00;
        if (l > r + 2) return 2'b01;
        if (r > l + 2) return 2'b10;
        return 2'b11;
    endfunction

    // kill_kind 0 = abort, 1 = reset, applied in cycle kill_k (0 = none).
    task automatic run_eval(input logic [11:0] fl, ml, mr, fr, input int hold,
                            input int kill_k, input int kill_kind, input bit abort_done);
        int L = clr + win * sdiv + 2;
        int el = 0, er = 0, mx = (1 << cwid) - 1;
        logic [1:0] edec;
        for (int k = 1; k < L; k++)
            if (pulse_at(k - 1)) begin el += int'(spk[k][0]); er += int'(spk[k][1]); end
        if (el > mx) el = mx;
        if (er > mx) er = mx;
        edec = decide(el, er);

        check("idle_in_ready", 32'(o_ready), 1);
        s_fl = fl; s_ml = ml; s_mr = mr; s_fr = fr; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        s_fl = 12'($urandom); s_ml = 12'($urandom); s_mr = 12'($urandom); s_fr = 12'($urandom);
        for (int k = 1; k <= L; k++) begin
            check("snn_en", 32'(o_en), 32'(pulse_at(k)));
            check("res_valid", 32'(o_rv), 32'(k == L));
            check("snn_rst", 32'(o_srst), 32'(!(k > clr && k < L)));
            check("in_ready_busy", 32'(o_ready), 0);
            if (k == 1 || k == L)
                check("snn_inputs", {o_fl, o_ml, o_mr, o_fr}, {fl, ml, mr, fr});
            if (k == kill_k) begin
                if (kill_kind == 0) begin
                    abort = 1'b1; spike = spk[k];
                    @(negedge clk);
                    abort = 1'b0;
                    check("abort_en", 32'(o_en), 0);
                    check("abort_idle", 32'(o_ready), 1);
                    check("abort_srst", 32'(o_srst), 1);
                    for (int j = 0; j < 4; j++) begin
                        check("abort_no_result", 32'(o_rv), 0);
                        @(negedge clk);
                    end
                end else begin
                    rst = 1'b0;
                    #1;
                    check("rst_en", 32'(o_en), 0);
                    check("rst_srst", 32'(o_srst), 1);
                    check("rst_rv", 32'(o_rv), 0);
                    check("rst_ready", 32'(o_ready), 1);
                    check("rst_counts", {o_cl, o_cr, 6'b0, o_dec}, 0);
                    check("rst_snn_in", {o_fl, o_ml, o_mr, o_fr}, 0);
                    @(negedge clk);
                    rst = 1'b1;
                    @(negedge clk);
                end
                return;
            end
            if (k < L) begin spike = spk[k]; @(negedge clk); end
        end
        check("cnt_l", 32'(o_cl), el);
        check("cnt_r", 32'(o_cr), er);
        check("decision", 32'(o_dec), 32'(edec));
        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0; in_valid = 1'b1; abort = abort_done;
            s_fl = 12'($urandom); s_ml = 12'($urandom);
            @(negedge clk);
            check("hold_rv", 32'(o_rv), 1);
            check("hold_ready", 32'(o_ready), 0);
            check("hold_result", {o_cl, o_cr, 14'b0, o_dec}, {8'(el), 8'(er), 14'b0, edec});
            check("hold_snn_in", {o_fl, o_ml, o_mr, o_fr}, {fl, ml, mr, fr});
        end
        res_ready = 1'b1; in_valid = 1'b0; abort = abort_done;
        @(negedge clk);
        res_ready = 1'b0; abort = 1'b0;
        check("release_rv", 32'(o_rv), 0);
        check("release_ready", 32'(o_ready), 1);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; res_ready = 1'b0; abort = 1'b0; spike = 2'b00;
        s_fl = '0; s_ml = '0; s_mr = '0; s_fr = '0;
        set_cfg(0);
        @(negedge clk); @(negedge clk);
        check("reset_ready", 32'(o_ready), 1);
        check("reset_srst", 32'(o_srst), 1);
        check("reset_en", 32'(o_en), 0);
        check("reset_rv", 32'(o_rv), 0);
        check("reset_result", {o_cl, o_cr, 6'b0, o_dec}, 0);
        check("reset_snn_in", {o_fl, o_ml, o_mr, o_fr}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Left spike on every sample cycle: 16/0, left.
        fill(0, 1, 0);
        run_eval(12'h123, 12'h456, 12'h789, 12'hABC, 0, 0, 0, 0);
        // Reset mid-RUN, then a fresh evaluation must be accepted.
        fill(3, 0, 0);
        run_eval(12'h111, 12'h222, 12'h333, 12'h444, 0, 20, 1, 0);
        // Spikes only outside sample cycles are ignored.
        fill(1, 2, 0);
        run_eval(12'h5A5, 12'h0F0, 12'hFFF, 12'h001, 0, 0, 0, 0);
        fill(2, 5, 5);
        run_eval(12'h010, 12'h020, 12'h030, 12'h040, 0, 0, 0, 0);
        fill(2, 3, 6);
        run_eval(12'h0AA, 12'h0BB, 12'h0CC, 12'h0DD, 0, 0, 0, 0);
        fill(2, 7, 4);
        run_eval(12'h321, 12'h654, 12'h987, 12'hCBA, 0, 0, 0, 0);
        // Backpressure in DONE with a competing sample offered.
        fill(3, 0, 0);
        run_eval(12'hDEA, 12'hDBE, 12'hEF0, 12'h0C0, 10, 0, 0, 0);
        // Aborts: 7th and 8th RUN cycle, and the DRAIN cycle.
        fill(3, 0, 0);
        run_eval(12'h777, 12'h888, 12'h999, 12'hAAA, 0, 9, 0, 0);
        run_eval(12'h778, 12'h889, 12'h99A, 12'hAAB, 0, 10, 0, 0);
        run_eval(12'h779, 12'h88A, 12'h99B, 12'hAAC, 0, clr + win * sdiv + 1, 0, 0);
        // abort in DONE is ignored.
        fill(2, 9, 1);
        run_eval(12'h246, 12'h468, 12'h68A, 12'h8AC, 3, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            fill(3, 0, 0);
            run_eval(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), i, 0, 0, 0);
        end

        // Saturating instance: 20 samples into 4-bit counters.
        set_cfg(1);
        fill(0, 3, 0);
        run_eval(12'hF00, 12'h0F0, 12'h00F, 12'hFFF, 2, 0, 0, 0);
        fill(2, 4, 0);
        run_eval(12'h123, 12'h321, 12'h213, 12'h132, 0, 0, 0, 0);
        fill(3, 0, 0);
        run_eval(12'h0E1, 12'h0E2, 12'h0E3, 12'h0E4, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
